// File: rtl/led7seg_scan_sequencer.sv
// Multiplexed refresh scheduler for an 8-digit 74HC595 LED chain: double-buffered
// frame, one {segments, one-hot select} word per refresh tick over vld/rdy.
module led7seg_scan_sequencer #(
  parameter int                 DIG_NUM   = 8,
  parameter int                 SEG_NUM   = 8,
  parameter int                 DIV_WIDTH = 17,
  parameter int                 DIV_LIM   = 125000,
  parameter logic [SEG_NUM-1:0] BLANK_PAT = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         blank,
  input  logic [DIG_NUM*SEG_NUM-1:0]   frm_dat,
  input  logic                         frm_vld,
  output logic                         frm_rdy,
  output logic [SEG_NUM+DIG_NUM-1:0]   out_dat,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [$clog2(DIG_NUM)-1:0]   dig_idx,
  output logic                         frm_done,
  output logic                         ovr
);

  localparam int IW = $clog2(DIG_NUM);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                       state_r, state_nx;
  logic [DIV_WIDTH-1:0]         div_r;
  logic                         tick_s;
  logic [DIG_NUM*SEG_NUM-1:0]   act_r, act_nx, shd_r, shd_nx;
  logic                         frm_rdy_r, frm_rdy_nx;
  logic [SEG_NUM+DIG_NUM-1:0]   out_dat_r, out_dat_nx;
  logic                         out_vld_r, out_vld_nx;
  logic [IW-1:0]                dig_r, dig_nx;
  logic                         done_r, done_nx;
  logic                         ovr_r, ovr_nx;
  logic                         swap_s;
  logic [SEG_NUM-1:0]           seg_s;
  logic [DIG_NUM-1:0]           sel_s;

  assign tick_s = en && (div_r == DIV_WIDTH'(DIV_LIM - 1));

  // Refresh divider: free-runs while enabled, parked at zero otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= {DIV_WIDTH{1'b0}};
    end else if (!en || tick_s) begin
      div_r <= {DIV_WIDTH{1'b0}};
    end else begin
      div_r <= div_r + DIV_WIDTH'(1);
    end
  end

  // Next-state, word build, frame swap and shadow load
  always_comb begin
    state_nx   = state_r;
    act_nx     = act_r;
    shd_nx     = shd_r;
    frm_rdy_nx = frm_rdy_r;
    out_dat_nx = out_dat_r;
    out_vld_nx = out_vld_r;
    dig_nx     = dig_r;
    done_nx    = 1'b0;
    ovr_nx     = ovr_r;
    sel_s      = {{(DIG_NUM-1){1'b0}}, 1'b1} << dig_r;
    // Swap needs a pending frame, so it never coincides with a load below
    swap_s     = (dig_r == {IW{1'b0}}) && !frm_rdy_r;
    if (blank) begin
      seg_s = BLANK_PAT;
    end else if (swap_s) begin
      seg_s = shd_r[dig_r*SEG_NUM +: SEG_NUM];
    end else begin
      seg_s = act_r[dig_r*SEG_NUM +: SEG_NUM];
    end

    if (frm_vld && frm_rdy_r) begin
      shd_nx     = frm_dat;
      frm_rdy_nx = 1'b0;
    end else begin
      shd_nx     = shd_r;
    end

    case (state_r)
      IDLE: begin
        if (tick_s) begin
          if (swap_s) begin
            act_nx     = shd_r;
            frm_rdy_nx = 1'b1;
          end else begin
            act_nx     = act_r;
          end
          out_dat_nx = {seg_s, sel_s};
          out_vld_nx = 1'b1;
          state_nx   = SEND;
        end else begin
          state_nx   = IDLE;
        end
      end
      SEND: begin
        if (tick_s) begin
          ovr_nx = 1'b1;
        end else begin
          ovr_nx = ovr_r;
        end
        if (out_rdy) begin
          out_vld_nx = 1'b0;
          state_nx   = IDLE;
          if (dig_r == IW'(DIG_NUM - 1)) begin
            dig_nx  = {IW{1'b0}};
            done_nx = 1'b1;
          end else begin
            dig_nx  = dig_r + IW'(1);
          end
        end else begin
          state_nx   = SEND;
        end
      end
      default: begin
        state_nx   = IDLE;
        out_vld_nx = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      act_r     <= {(DIG_NUM*SEG_NUM){1'b0}};
      shd_r     <= {(DIG_NUM*SEG_NUM){1'b0}};
      frm_rdy_r <= 1'b1;
      out_dat_r <= {(SEG_NUM+DIG_NUM){1'b0}};
      out_vld_r <= 1'b0;
      dig_r     <= {IW{1'b0}};
      done_r    <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      state_r   <= state_nx;
      act_r     <= act_nx;
      shd_r     <= shd_nx;
      frm_rdy_r <= frm_rdy_nx;
      out_dat_r <= out_dat_nx;
      out_vld_r <= out_vld_nx;
      dig_r     <= dig_nx;
      done_r    <= done_nx;
      ovr_r     <= ovr_nx;
    end
  end

  assign frm_rdy  = frm_rdy_r;
  assign out_dat  = out_dat_r;
  assign out_vld  = out_vld_r;
  assign dig_idx  = dig_r;
  assign frm_done = done_r;
  assign ovr      = ovr_r;

endmodule

// File: tb/tb_led7seg_scan_sequencer.sv
// Bench for led7seg_scan_sequencer: directed scenarios plus random traffic, every
// cycle compared with a transaction-level scan model.
module tb_led7seg_scan_sequencer;

  localparam int DL = 4;

  logic        clk = 1'b0;
  logic        rst, en, blank, frm_vld, frm_rdy, out_vld, out_rdy, frm_done, ovr;
  logic [63:0] frm_dat;
  logic [15:0] out_dat;
  logic [2:0]  dig_idx;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // model state
  int          m_run, m_dig;
  logic [7:0]  m_act [8];
  logic [7:0]  m_shd [8];
  bit          m_pend, m_vld, m_done, m_ovr;
  logic [15:0] m_word;

  always #5 clk = ~clk;

  led7seg_scan_sequencer #(.DIV_LIM(DL)) dut (
    .clk(clk), .rst(rst), .en(en), .blank(blank), .frm_dat(frm_dat),
    .frm_vld(frm_vld), .frm_rdy(frm_rdy), .out_dat(out_dat), .out_vld(out_vld),
    .out_rdy(out_rdy), .dig_idx(dig_idx), .frm_done(frm_done), .ovr(ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_dig = 0; m_pend = 0; m_vld = 0; m_done = 0; m_ovr = 0; m_word = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 8'h00;
      m_shd[i] = 8'h00;
    end
  endtask

  // One clock: advance the model from the current inputs, then compare every output.
  task automatic cyc();
    bit tick, pend0;
    pend0  = m_pend;
    m_done = 0;
    if (rst) begin
      model_reset();
    end else begin
      tick  = en && (m_run % DL == DL - 1);
      m_run = en ? m_run + 1 : 0;
      if (!m_vld) begin
        if (tick) begin
          if (m_dig == 0 && pend0) begin
            for (int i = 0; i < 8; i++) m_act[i] = m_shd[i];
            m_pend = 0;
          end
          m_word = {(blank ? 8'hFF : m_act[m_dig]), 8'(1 << m_dig)};
          m_vld  = 1;
        end
      end else begin
        if (tick) m_ovr = 1;
        if (out_rdy) begin
          m_vld  = 0;
          m_done = (m_dig == 7);
          m_dig  = (m_dig + 1) % 8;
        end
      end
      if (frm_vld && !pend0) begin
        for (int i = 0; i < 8; i++) m_shd[i] = frm_dat[i*8 +: 8];
        m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("out_vld", 32'(out_vld), 32'(m_vld));
    chk("out_dat", 32'(out_dat), 32'(m_word));
    chk("dig_idx", 32'(dig_idx), 32'(m_dig));
    chk("frm_rdy", 32'(frm_rdy), 32'(!m_pend));
    chk("frm_done", 32'(frm_done), 32'(m_done));
    chk("ovr", 32'(ovr), 32'(m_ovr));
  endtask

  task automatic wait_vld(input string tag, input int budget, output int n);
    n = 0;
    while (!out_vld && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(out_vld), 32'd1);
  endtask

  initial begin
    int          n, words, dones, last_t;
    logic [15:0] held;
    logic [2:0]  held_dig;
    logic [63:0] frame_b;
    bit          prev;

    model_reset();
    rst = 1'b1; en = 1'b0; blank = 1'b0; frm_vld = 1'b0; out_rdy = 1'b1; frm_dat = 64'h0;
    cyc(); cyc();
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_rdy", 32'(frm_rdy), 32'd1);
    chk("rst_dat", 32'(out_dat), 32'd0);
    rst = 1'b0;

    // 1: one full scan of C0..C7
    for (int i = 0; i < 8; i++) frm_dat[i*8 +: 8] = 8'hC0 + 8'(i);
    frm_vld = 1'b1; en = 1'b1;
    cyc();
    frm_vld = 1'b0;
    words = 0; dones = 0; prev = out_vld; last_t = 0;
    for (int t = 1; t < 35; t++) begin
      cyc();
      if (frm_done) dones++;
      if (out_vld && !prev) begin
        if (words < 8) chk("scan_word", 32'(out_dat), 32'({8'hC0 + 8'(words), 8'(1 << words)}));
        if (words > 0) chk("scan_spacing", 32'(t - last_t), 32'(DL));
        last_t = t;
        words++;
      end
      prev = out_vld;
    end
    chk("scan_words", 32'(words), 32'd8);
    chk("scan_dones", 32'(dones), 32'd1);
    chk("scan_rdy", 32'(frm_rdy), 32'd1);

    // 2: stall the consumer
    wait_vld("stall_wait", 3 * DL, n);
    out_rdy = 1'b0;
    held = out_dat; held_dig = dig_idx;
    for (int i = 0; i < 10; i++) cyc();
    chk("stall_dat", 32'(out_dat), 32'(held));
    chk("stall_dig", 32'(dig_idx), 32'(held_dig));
    chk("stall_ovr", 32'(ovr), 32'd1);
    out_rdy = 1'b1;
    cyc();
    wait_vld("stall_next", 2 * DL, n);
    chk("stall_next_dig", 32'(dig_idx), 32'((held_dig + 3'd1)));
    chk("stall_ovr_sticky", 32'(ovr), 32'd1);

    // 3: frame B after digit 3, third load ignored
    n = 0;
    while (!(dig_idx == 3'd4 && !out_vld) && n < 20 * DL) begin cyc(); n++; end
    chk("fb_reach", 32'(dig_idx), 32'd4);
    frame_b = {$urandom, $urandom};
    frm_dat = frame_b; frm_vld = 1'b1;
    cyc();
    chk("fb_rdy_low", 32'(frm_rdy), 32'd0);
    frm_dat = ~frame_b;
    cyc();
    frm_vld = 1'b0;
    n = 0;
    while (!(out_vld && dig_idx == 3'd0) && n < 20 * DL) begin cyc(); n++; end
    chk("fb_word", 32'(out_dat), 32'({frame_b[7:0], 8'h01}));
    chk("fb_rdy_back", 32'(frm_rdy), 32'd1);

    // 4: blanked scan
    blank = 1'b1;
    prev = out_vld;
    for (int t = 0; t < 8 * DL; t++) begin
      cyc();
      if (out_vld && !prev) chk("blank_word", 32'(out_dat), 32'({8'hFF, 8'(1 << dig_idx)}));
      prev = out_vld;
    end
    blank = 1'b0;

    // 5: reset mid-SEND
    out_rdy = 1'b0;
    wait_vld("rst_wait", 3 * DL, n);
    rst = 1'b1;
    cyc();
    rst = 1'b0; out_rdy = 1'b1;
    chk("mrst_vld", 32'(out_vld), 32'd0);
    chk("mrst_dig", 32'(dig_idx), 32'd0);
    chk("mrst_rdy", 32'(frm_rdy), 32'd1);
    chk("mrst_ovr", 32'(ovr), 32'd0);
    wait_vld("mrst_first", 3 * DL, n);
    chk("mrst_latency", 32'(n + 1), 32'(DL + 1));
    chk("mrst_word", 32'(out_dat), 32'h0001);

    // 6: enable gap
    cyc();
    en = 1'b0;
    words = 0;
    for (int t = 0; t < 20; t++) begin
      cyc();
      if (out_vld) words++;
    end
    chk("en_off_vld", 32'(words), 32'd0);
    en = 1'b1;
    wait_vld("en_on", 3 * DL, n);
    chk("en_latency", 32'(n), 32'(DL));

    // random traffic
    for (int t = 0; t < 600; t++) begin
      rst     = ($urandom_range(0, 199) == 0);
      en      = ($urandom_range(0, 9) != 0);
      blank   = ($urandom_range(0, 7) == 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      frm_vld = ($urandom_range(0, 5) == 0);
      frm_dat = {$urandom, $urandom};
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led7seg_scan_sequencer.md
Name: led7seg_scan_sequencer

Overview:
Refresh scheduler for the 8-digit 74HC595 LED 7-segment chain. Holds a double-buffered frame of per-digit segment patterns and emits one 16-bit {segment, digit-select} word per refresh tick to the serial shift controller over a vld/rdy handshake. Sits between the timer/BCD-decode logic, which produces frames, and mfe_led7seg_74hc595_controller, which consumes words. It replaces ad-hoc per-second word muxing with a fixed-rate multiplexed scan.

Parameters:
DIG_NUM, 8, number of digits scanned; select field is one-hot, DIG_NUM bits.
SEG_NUM, 8, segment bits per digit.
DIV_WIDTH, 17, width of the refresh-tick divider.
DIV_LIM, 125000, clk cycles per digit slot (1 kHz at 125 MHz); must be at least 2.
BLANK_PAT, 8'hFF, segment pattern driven while blanked (all segments off).

Ports:
clk  in  1  system clock, 125 MHz
rst  in  1  synchronous reset, active-high
en  in  1  scan enable
blank  in  1  force BLANK_PAT on the segment field
frm_dat  in  DIG_NUM*SEG_NUM  frame; digit i pattern at [i*SEG_NUM +: SEG_NUM]
frm_vld  in  1  frame load request
frm_rdy  out  1  shadow buffer free
out_dat  out  SEG_NUM+DIG_NUM  {segments, one-hot select}; digit i select = 1<<i
out_vld  out  1  word valid to shift controller
out_rdy  in  1  shift controller ready
dig_idx  out  3  digit currently scheduled
frm_done  out  1  1-cycle pulse when the last digit's word is accepted
ovr  out  1  sticky overrun flag

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on posedge clk; rst has priority over every other input.
- Reset values: out_vld=0, out_dat=0, dig_idx=0, frm_rdy=1 (pending flag clear), active buffer=0, shadow buffer=0, frm_done=0, ovr=0, divider=0, state=IDLE.
- Divider: counts 0..DIV_LIM-1 and wraps to 0. tick=1 when count==DIV_LIM-1. While en=0 the divider is held at 0 and no tick occurs.
- Shadow load:
  - frm_rdy = ~pend.
  - When frm_vld & frm_rdy: shadow <= frm_dat and pend <= 1.
  - frm_vld while frm_rdy=0 is ignored; the shadow buffer is not overwritten.
- FSM states: IDLE, SEND.
  - IDLE, tick: build the word for dig_idx, register it into out_dat, set out_vld=1, go to SEND. out_vld therefore rises the cycle after the tick.
  - Word build: segment field = BLANK_PAT if blank, else the dig_idx slice of the active buffer. blank is sampled on the build cycle.
  - Frame swap: happens only when building the digit-0 word with pend=1. In that cycle active <= shadow, pend <= 0, and the word is built from the shadow data directly. frm_rdy rises the next cycle. Since a swap requires pend=1, frm_rdy=0 on swap cycles, so a load and a swap can never coincide.
  - SEND: out_dat and out_vld are held stable until out_rdy=1.
  - SEND, out_rdy=1: out_vld <= 0, go to IDLE. If dig_idx==DIG_NUM-1, dig_idx <= 0 and frm_done pulses; otherwise dig_idx <= dig_idx+1.
  - SEND, tick: that tick is dropped (no queueing) and ovr <= 1. ovr is cleared only by rst.
  - en falling during SEND: the handshake still completes; no further words are issued.
- out_dat remains at its last value while in IDLE.

Test Plan:
1. DIV_LIM=4, out_rdy=1, load frame with digit i = 8'hC0+i -> words 16'hC001, C102, C204, C308, C410, C520, C640, C780 at 4-cycle spacing; frm_done pulses once, on the cycle after C780 is accepted; frm_rdy=1 after the digit-0 swap.
2. out_rdy held low 10 cycles during SEND with DIV_LIM=4 -> out_dat stable, dig_idx unchanged, ovr=1. After out_rdy=1 the next digit's word is issued on the next tick; ovr stays 1.
3. Frame A loaded; frame B loaded after digit 3 is sent -> digits 4..7 use A, frm_rdy=0, and a third frm_vld is ignored. The next scan's digit-0 word uses B's byte and frm_rdy returns to 1.
4. blank=1 across one scan -> out_dat = 16'hFF01, FF02 .. FF80; the select field keeps walking.
5. rst asserted mid-SEND -> next cycle out_vld=0, dig_idx=0, frm_rdy=1, ovr=0. The first word after reset appears DIV_LIM+1 cycles later and equals 16'h0001.
6. en=0 for 20 cycles -> no out_vld. After en=1, the first out_vld occurs DIV_LIM cycles later.
